msg_scroller: RTL and testbench
===============================

# msg_scroller

Single-clock, parametrised message scroller that replaces the derived-clock divider/scroller pair in the display path. It holds a writable message buffer and generates scroll steps from an internal prescaler enable, so it needs no generated clocks. It supports bidirectional scrolling, hold, blink and a configurable blank gap, and emits a packed character bus to the existing per-digit ASCII-to-segment converters.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- RATE_SLOW_HZ, 1, step rate when speed=0
- RATE_FAST_HZ, 10, step rate when speed=1
- MSG_MAX, 32, message buffer depth in characters (≥1)
- CHAR_WIDTH, 8, bits per character
- NUM_DISPLAYS, 6, digits driven
- GAP, NUM_DISPLAYS, blank characters appended after the message before it repeats (≥0)
- BLANK_CHAR, 8'h20, character shown for blanks, idle and blink-off
- AW, $clog2(MSG_MAX), derived address width; LW = $clog2(MSG_MAX+1)

- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous active-low reset
- dir  in  1  0 = text moves left-to-right (offset decrements), 1 = right-to-left (offset increments)
- speed  in  1  0 = RATE_SLOW_HZ, 1 = RATE_FAST_HZ
- hold  in  1  freeze the scroll position; the prescaler also stops
- blink_en  in  1  toggle between frame and all-BLANK on every tick
- wr_en  in  1  write the message buffer
- wr_addr  in  AW  buffer write address; wr_addr ≥ MSG_MAX is ignored
- wr_data  in  CHAR_WIDTH  character to write
- load  in  1  start or restart scrolling with msg_len
- msg_len  in  LW  message length, sampled on load
- stop  in  1  return to IDLE
- display_chars  out  NUM_DISPLAYS*CHAR_WIDTH  slice k drives digit k; digit NUM_DISPLAYS-1 is leftmost
- step_pulse  out  1  one-cycle strobe when display_chars takes a new scroll position
- wrap_pulse  out  1  one-cycle strobe when the offset wraps
- busy  out  1  high in RUN

## Operation
- The virtual stream is msg[0..L-1] followed by GAP blanks, with period P = L+GAP. The offset ofs lies in 0..P-1.
- Digit k shows stream[(ofs + NUM_DISPLAYS-1-k) mod P]. When P < NUM_DISPLAYS, indices repeat modulo P.
- Prescaler:
  - DIV = CLK_HZ/RATE_x, with integer division and a minimum of 1.
  - The counter counts 0..DIV-1, and tick is asserted on the cycle the count equals DIV-1.
  - Any change of speed clears the counter to 0 on that cycle; no tick is produced that cycle.
- States:
  - IDLE: display shows all BLANK_CHAR, busy=0, prescaler held at 0. load with msg_len≥1 → RUN. load with msg_len=0 is ignored.
  - RUN: on each tick with hold=0, ofs advances by ±1 mod P according to dir.
  - Leave RUN for IDLE on stop.
- On load:
  - L = min(msg_len, MSG_MAX).
  - ofs = 0, prescaler = 0, blink phase = on.
  - load in RUN restarts with the new L.
  - load with msg_len=0 in RUN → IDLE.
- Simultaneous events:
  - stop has priority over load.
  - load has priority over a tick in the same cycle.
- Writes:
  - Buffer writes are accepted in any state.
  - A write lands at the clock edge and appears in display_chars on the next edge if its index is in view.
  - Buffer contents are not reset and are undefined until written.
- wrap_pulse asserts with the step into ofs=0 when dir=1, and with the step into ofs=P-1 when dir=0.
- Blink:
  - Each tick in RUN toggles the blink phase when blink_en=1.
  - A tick while hold=1 and blink_en=1 toggles blink only.
  - In the off phase, all digits show BLANK_CHAR.
  - When blink_en=0, the phase is forced to on.

## Timing
- Reset (async assert, synchronous release) sets:
  - state=IDLE, ofs=0, prescaler=0, blink phase on
  - display_chars = all BLANK_CHAR
  - step_pulse=0, wrap_pulse=0, busy=0
- On the tick edge, ofs and the blink phase update. display_chars is registered and reflects the new ofs one clock later.
- step_pulse and wrap_pulse are high on the same cycle that display_chars first shows the new frame.
- After load at edge n:
  - busy=1 from edge n.
  - The ofs=0 frame appears at edge n+1.
  - The first step occurs DIV clocks after the load edge.
- stop at edge n: busy=0 at edge n, all-BLANK display at edge n+1.
- A change of dir takes effect on the next tick. There is no extra latency.

## Test plan
Common setup for all scenarios: CLK_HZ=20, RATE_SLOW_HZ=1 (DIV=20), RATE_FAST_HZ=10 (DIV=2), NUM_DISPLAYS=6, GAP=6, MSG_MAX=16.

1. Reset mid-RUN → on assertion, display_chars = 6×8'h20, busy=0 and pulses=0 with no clock edge.
2. Write "HELLO" at addresses 0..4, load with msg_len=5, dir=1, speed=1 (P=11).
   - First frame, digits 5..0: H,E,L,L,O,blank.
   - A step every 2 clocks; after 1 step: E,L,L,O,blank,blank.
   - wrap_pulse after the 11th step, with the frame again H,E,L,L,O,blank.
3. Same message, dir=0:
   - First step → ofs=10 with frame blank,H,E,L,L,O, and wrap_pulse asserted on that step.
   - hold=1 for 10 clocks → no step_pulse; resume → next step ≤2 clocks later.
4. Toggle speed 1→0 mid-count → the prescaler clears that cycle, and the next step occurs exactly 20 clocks later.
5. Edge cases:
   - msg_len=20 → clamped to L=16.
   - msg_len=0 in IDLE → stays IDLE.
   - load and stop in the same cycle → IDLE.
   - A write to an in-view address during RUN → the new character appears on the next edge.
6. blink_en=1 with hold=1 → the display alternates between frame and all-BLANK every 2 clocks while ofs stays constant; blink_en=0 → the frame is restored immediately (next edge).

Source files
------------

// File: rtl/msg_scroller.sv
// msg_scroller: single-clock message scroller with a writable buffer.
// A prescaler enable generates scroll/blink ticks, so no derived clocks are needed.
// The registered frame feeds the per-digit ASCII-to-segment converters.
module msg_scroller #(
  parameter int                   CLK_HZ       = 50_000_000,
  parameter int                   RATE_SLOW_HZ = 1,
  parameter int                   RATE_FAST_HZ = 10,
  parameter int                   MSG_MAX      = 32,
  parameter int                   CHAR_WIDTH   = 8,
  parameter int                   NUM_DISPLAYS = 6,
  parameter int                   GAP          = NUM_DISPLAYS,
  parameter logic [CHAR_WIDTH-1:0] BLANK_CHAR  = 8'h20,
  parameter int                   AW           = $clog2(MSG_MAX),
  parameter int                   LW           = $clog2(MSG_MAX+1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               dir,
  input  logic                               speed,
  input  logic                               hold,
  input  logic                               blink_en,
  input  logic                               wr_en,
  input  logic [AW-1:0]                      wr_addr,
  input  logic [CHAR_WIDTH-1:0]              wr_data,
  input  logic                               load,
  input  logic [LW-1:0]                      msg_len,
  input  logic                               stop,
  output logic [NUM_DISPLAYS*CHAR_WIDTH-1:0] display_chars,
  output logic                               step_pulse,
  output logic                               wrap_pulse,
  output logic                               busy
);

  localparam int DIV_SLOW = (CLK_HZ / RATE_SLOW_HZ < 1) ? 1 : CLK_HZ / RATE_SLOW_HZ;
  localparam int DIV_FAST = (CLK_HZ / RATE_FAST_HZ < 1) ? 1 : CLK_HZ / RATE_FAST_HZ;
  localparam int DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int CNTW     = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int PW       = $clog2(MSG_MAX + GAP + 1);
  localparam int DW       = NUM_DISPLAYS * CHAR_WIDTH;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [PW-1:0]         ofs_q, ofs_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  blink_q, blink_d;
  logic                  speed_q;
  logic                  step_pend_q, step_pend_d;
  logic                  wrap_pend_q, wrap_pend_d;
  logic                  step_q, wrap_q;
  logic [DW-1:0]         disp_q, disp_d;
  logic [CHAR_WIDTH-1:0] mem_q [MSG_MAX];

  logic                  run, spd_chg, pre_en, tick, wr_ok;
  logic [CNTW-1:0]       div_m1;
  logic [PW-1:0]         period, period_m1, idx;
  logic [LW-1:0]         len_clamp;
  logic [DW-1:0]         frame;

  assign run       = (state_q == S_RUN);
  assign spd_chg   = speed ^ speed_q;
  assign div_m1    = speed ? CNTW'(DIV_FAST - 1) : CNTW'(DIV_SLOW - 1);
  // prescaler keeps running under hold while blinking so the blink phase still toggles
  assign pre_en    = run && (!hold || blink_en);
  assign tick      = pre_en && !spd_chg && (cnt_q == div_m1);
  assign period    = PW'(len_q) + PW'(GAP);
  assign period_m1 = period - PW'(1);
  assign len_clamp = (int'(msg_len) > MSG_MAX) ? LW'(MSG_MAX) : msg_len;
  assign wr_ok     = wr_en && (int'(wr_addr) < MSG_MAX);

  // Message buffer: not reset, written in any state.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= wr_data;
  end

  // Frame builder: walks the stream from the leftmost digit, wrapping at the period
  // with a compare instead of a modulo.
  always_comb begin
    idx   = ofs_q;
    frame = '0;
    for (int unsigned i = 0; i < NUM_DISPLAYS; i++) begin
      if (idx < PW'(len_q)) frame[(NUM_DISPLAYS-1-i)*CHAR_WIDTH +: CHAR_WIDTH] = mem_q[idx[AW-1:0]];
      else                  frame[(NUM_DISPLAYS-1-i)*CHAR_WIDTH +: CHAR_WIDTH] = BLANK_CHAR;
      idx = (idx == period_m1) ? '0 : idx + PW'(1);
    end
    disp_d = (run && (blink_q || !blink_en)) ? frame : {NUM_DISPLAYS{BLANK_CHAR}};
  end

  // Next-state: prescaler, offset stepping, blink phase; stop beats load beats tick.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ofs_d       = ofs_q;
    blink_d     = blink_q;
    step_pend_d = 1'b0;
    wrap_pend_d = 1'b0;

    if (!run || spd_chg) cnt_d = '0;
    else if (pre_en)     cnt_d = (cnt_q == div_m1) ? '0 : cnt_q + CNTW'(1);
    else                 cnt_d = cnt_q;

    if (tick) begin
      if (blink_en) blink_d = ~blink_q;
      if (!hold) begin
        step_pend_d = 1'b1;
        if (dir) begin
          wrap_pend_d = (ofs_q == period_m1);
          ofs_d       = (ofs_q == period_m1) ? '0 : ofs_q + PW'(1);
        end else begin
          wrap_pend_d = (ofs_q == '0);
          ofs_d       = (ofs_q == '0) ? period_m1 : ofs_q - PW'(1);
        end
      end
    end

    if (!blink_en) blink_d = 1'b1;

    if (stop || (load && (msg_len == '0))) begin
      state_d     = S_IDLE;
      ofs_d       = '0;
      cnt_d       = '0;
      blink_d     = 1'b1;
      step_pend_d = 1'b0;
      wrap_pend_d = 1'b0;
    end else if (load) begin
      state_d     = S_RUN;
      len_d       = len_clamp;
      ofs_d       = '0;
      cnt_d       = '0;
      blink_d     = 1'b1;
      step_pend_d = 1'b0;
      wrap_pend_d = 1'b0;
    end
  end

  // State registers; step/wrap strobes are delayed one clock to line up with the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      ofs_q       <= '0;
      cnt_q       <= '0;
      blink_q     <= 1'b1;
      speed_q     <= 1'b0;
      step_pend_q <= 1'b0;
      wrap_pend_q <= 1'b0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      disp_q      <= {NUM_DISPLAYS{BLANK_CHAR}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ofs_q       <= ofs_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      speed_q     <= speed;
      step_pend_q <= step_pend_d;
      wrap_pend_q <= wrap_pend_d;
      step_q      <= step_pend_q;
      wrap_q      <= wrap_pend_q;
      disp_q      <= disp_d;
    end
  end

  assign display_chars = disp_q;
  assign step_pulse    = step_q;
  assign wrap_pulse    = wrap_q;
  assign busy          = run;

endmodule

// File: tb/tb_msg_scroller.sv
// Testbench for msg_scroller: stream-level model checked every cycle plus directed literal checks.
module tb_msg_scroller;

  localparam int GAPV  = 6;
  localparam int MSGM  = 16;
  localparam int DIV_S = 20;
  localparam int DIV_F = 2;
  localparam logic [47:0] BL       = {6{8'h20}};
  localparam logic [47:0] F_HELLO  = 48'h48454C4C4F20;  // H E L L O _
  localparam logic [47:0] F_ELLO   = 48'h454C4C4F2020;  // E L L O _ _
  localparam logic [47:0] F_RHELLO = 48'h2048454C4C4F;  // _ H E L L O
  localparam logic [47:0] F_CLAMP  = 48'h48454C4C4F66;  // H E L L O f
  localparam logic [47:0] F_X      = 48'h4845584C4F20;  // H E X L O _

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dir = 1'b0, speed = 1'b0, hold = 1'b0, blink_en = 1'b0;
  logic        wr_en = 1'b0, load = 1'b0, stop = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [4:0]  msg_len = '0;
  logic [47:0] display_chars;
  logic        step_pulse, wrap_pulse, busy;

  int n_chk = 0;
  int n_fail = 0;

  msg_scroller #(
    .CLK_HZ(20), .RATE_SLOW_HZ(1), .RATE_FAST_HZ(10), .MSG_MAX(16),
    .CHAR_WIDTH(8), .NUM_DISPLAYS(6), .GAP(6), .BLANK_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dir(dir), .speed(speed), .hold(hold),
    .blink_en(blink_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load(load), .msg_len(msg_len), .stop(stop), .display_chars(display_chars),
    .step_pulse(step_pulse), .wrap_pulse(wrap_pulse), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mm [MSGM];
  bit          m_run = 0;
  int          m_len = 0, m_ofs = 0, m_cnt = 0;
  bit          m_blink = 1, m_spd = 0, p_s = 0, p_w = 0;
  logic [47:0] e_disp = BL;
  bit          e_step = 0, e_wrap = 0, e_busy = 0;

  function automatic logic [47:0] mframe(input int ofs, input int len);
    logic [47:0] f;
    int p, i;
    p = len + GAPV;
    for (int k = 0; k < 6; k++) begin
      i = (ofs + 5 - k) % p;
      f[k*8 +: 8] = (i < len) ? mm[i] : 8'h20;
    end
    return f;
  endfunction

  task automatic m_idle();
    m_run = 0; m_ofs = 0; m_cnt = 0; m_blink = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_idle(); m_len = 0; m_spd = 0; p_s = 0; p_w = 0;
        e_disp = BL; e_step = 0; e_wrap = 0; e_busy = 0;
      end else begin
        int  div, p;
        bit  chg, act, tk;
        div = speed ? DIV_F : DIV_S;
        chg = (speed != m_spd);
        e_disp = (m_run && (m_blink || !blink_en)) ? mframe(m_ofs, m_len) : BL;
        e_step = p_s; e_wrap = p_w; p_s = 0; p_w = 0;
        if (wr_en && int'(wr_addr) < MSGM) mm[wr_addr] = wr_data;
        if (stop) m_idle();
        else if (load) begin
          if (msg_len == 0) m_idle();
          else begin
            m_run = 1; m_len = (int'(msg_len) > MSGM) ? MSGM : int'(msg_len);
            m_ofs = 0; m_cnt = 0; m_blink = 1;
          end
        end else if (m_run) begin
          act = !hold || blink_en;
          tk  = act && !chg && (m_cnt == div - 1);
          if (chg) m_cnt = 0;
          else if (act) m_cnt = (m_cnt == div - 1) ? 0 : m_cnt + 1;
          if (tk) begin
            if (blink_en) m_blink = !m_blink;
            if (!hold) begin
              p = m_len + GAPV;
              if (dir) begin m_ofs = (m_ofs + 1) % p;     p_w = (m_ofs == 0);     end
              else     begin m_ofs = (m_ofs + p - 1) % p; p_w = (m_ofs == p - 1); end
              p_s = 1;
            end
          end
        end
        if (!blink_en) m_blink = 1;
        m_spd  = speed;
        e_busy = m_run;
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_disp", display_chars, e_disp);
      chk("model_step", 48'(step_pulse), 48'(e_step));
      chk("model_wrap", 48'(wrap_pulse), 48'(e_wrap));
      chk("model_busy", 48'(busy), 48'(e_busy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic at_pos();
    @(posedge clk); #1;
  endtask

  task automatic ld(input int len);
    at_pos(); load = 1; msg_len = 5'(len);
    at_pos(); load = 0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    at_pos(); wr_en = 1; wr_addr = 4'(a); wr_data = d;
    at_pos(); wr_en = 0;
  endtask

  task automatic wait_step(input int bound, output int n);
    bit found = 0;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); n++;
      if (step_pulse) begin found = 1; break; end
    end
    if (!found) n = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    int steps, n;
    logic [47:0] pat6 [8];
    pat6 = '{F_HELLO, F_HELLO, F_HELLO, BL, BL, F_HELLO, F_HELLO, BL};

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_disp", display_chars, BL);
    chk("reset_busy", 48'(busy), 48'd0);

    // fill buffer 'a'..'p', then "HELLO" at 0..4
    at_pos();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 8'h61 + 8'(i); at_pos();
    end
    wr_en = 0;
    wr(0, 8'h48); wr(1, 8'h45); wr(2, 8'h4C); wr(3, 8'h4C); wr(4, 8'h4F);

    // dir=1, fast, P=11
    speed = 1; dir = 1;
    ld(5);
    @(negedge clk); chk("load_busy", 48'(busy), 48'd1);
                    chk("load_disp_blank", display_chars, BL);
    @(negedge clk); chk("first_frame", display_chars, F_HELLO);
    @(negedge clk); chk("no_step_yet", 48'(step_pulse), 48'd0);
    @(negedge clk); chk("step1_pulse", 48'(step_pulse), 48'd1);
                    chk("step1_frame", display_chars, F_ELLO);
    steps = 1;
    for (int i = 0; i < 40 && steps < 11; i++) begin
      @(negedge clk);
      if (step_pulse) steps++;
    end
    chk("wrap_step_count", 48'(steps), 48'd11);
    chk("wrap_pulse_r", 48'(wrap_pulse), 48'd1);
    chk("wrap_frame_r", display_chars, F_HELLO);

    // dir=0: first step wraps to ofs=10
    dir = 0;
    ld(5);
    @(negedge clk);
    @(negedge clk); chk("l_first_frame", display_chars, F_HELLO);
    @(negedge clk);
    @(negedge clk); chk("l_step_frame", display_chars, F_RHELLO);
                    chk("l_wrap_pulse", 48'(wrap_pulse), 48'd1);

    // hold freezes stepping
    at_pos(); hold = 1;
    repeat (2) @(negedge clk);
    steps = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (step_pulse) steps++;
    end
    chk("hold_no_steps", 48'(steps), 48'd0);
    at_pos(); hold = 0;
    wait_step(10, n);
    chk("resume_latency", 48'(n), 48'd4);

    // speed 1->0 mid-count: counter clears, next step 20 clocks after the clear
    speed = 0;
    wait_step(40, n);
    chk("speed_change_latency", 48'(n), 48'd22);
    at_pos(); speed = 1;

    // msg_len=20 clamps to 16 (P=22)
    dir = 1;
    ld(20);
    @(negedge clk); chk("clamp_busy", 48'(busy), 48'd1);
    @(negedge clk); chk("clamp_frame", display_chars, F_CLAMP);
    steps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (step_pulse) steps++;
      if (wrap_pulse) break;
    end
    chk("clamp_period", 48'(steps), 48'd22);

    // stop
    at_pos(); stop = 1;
    at_pos(); stop = 0;
    @(negedge clk); chk("stop_busy", 48'(busy), 48'd0);
    @(negedge clk); chk("stop_blank", display_chars, BL);

    // msg_len=0 in IDLE is ignored
    ld(0);
    @(negedge clk); chk("len0_busy", 48'(busy), 48'd0);
    @(negedge clk); chk("len0_blank", display_chars, BL);

    // load and stop together while running
    ld(5);
    at_pos(); load = 1; stop = 1; msg_len = 5'd5;
    at_pos(); load = 0; stop = 0;
    @(negedge clk); chk("ldstop_busy", 48'(busy), 48'd0);
    @(negedge clk); chk("ldstop_blank", display_chars, BL);

    // in-view write during RUN (held)
    hold = 1;
    ld(5);
    @(negedge clk);
    @(negedge clk); chk("held_frame", display_chars, F_HELLO);
    wr(2, 8'h58);
    @(negedge clk); chk("write_not_yet", display_chars, F_HELLO);
    @(negedge clk); chk("write_visible", display_chars, F_X);
    wr(2, 8'h4C);
    repeat (2) @(negedge clk);

    // blink under hold
    at_pos(); blink_en = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("blink_%0d", i), display_chars, pat6[i]);
    end
    blink_en = 0;
    @(negedge clk); chk("blink_off_restore", display_chars, F_HELLO);

    // reset asserted mid-RUN takes effect without a clock edge
    at_pos(); hold = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_disp", display_chars, BL);
    chk("async_rst_busy", 48'(busy), 48'd0);
    chk("async_rst_step", 48'(step_pulse), 48'd0);
    chk("async_rst_wrap", 48'(wrap_pulse), 48'd0);
    at_pos(); rst_n = 1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
